// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory access controller.
// The WRITE state only exists when DM_SUBWORD_EN is defined.
package dm_pkg;

    localparam int DM_AW_DEF = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] WE_IDLE  = 2'b00;
    localparam logic [1:0] WE_WRITE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
`ifdef DM_SUBWORD_EN
        , ST_WRITE = 2'd3
`endif
    } state_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: little-endian load lane extraction/extension and store merge.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] ld,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;

    assign sh   = {off, 3'b000};
    assign b    = 8'(rd >> sh);
    assign h    = 16'(rd >> sh);
    assign mask = (size == SZ_BYTE) ? 32'h0000_00FF :
                  (size == SZ_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    assign ld = (size == SZ_BYTE) ? {{24{b[7] & ~uns}}, b} :
                (size == SZ_HALF) ? {{16{h[15] & ~uns}}, h} : rd;

    assign merged = (rd & ~(mask << sh)) | ((wd << sh) & (mask << sh));

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: CPU-side data-memory access sequencer (load, store, read-modify-write).
// Define DM_SUBWORD_EN for byte/halfword accesses and misalignment checks.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [DM_AW+1:0]  REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic [1:0]        DMWE,
    output logic [DM_AW-1:0]  DMA,
    output logic [31:0]       DMWD,
    input  logic [31:0]       DMRD
);

    state_t      state, state_nx;
    logic        accept, mis, uns_in;
    logic [1:0]  size_in, off_in;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] rdata_q, ld, merged;

`ifdef DM_SUBWORD_EN
    assign size_in = REQ_SIZE;
    assign off_in  = REQ_ADDR[1:0];
    assign uns_in  = REQ_UNSIGNED;
    assign mis     = (REQ_SIZE == SZ_HALF && REQ_ADDR[0]) ||
                     (is_word(REQ_SIZE) && REQ_ADDR[1:0] != 2'b00);
`else
    logic unused_ok;
    assign size_in   = SZ_WORD;
    assign off_in    = 2'b00;
    assign uns_in    = 1'b0;
    assign mis       = 1'b0;
    assign unused_ok = ^{REQ_SIZE, REQ_UNSIGNED, REQ_ADDR[1:0]};
`endif

    assign accept = state == ST_IDLE && REQ_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = !REQ_VALID ? ST_IDLE : mis ? ST_RESP : ST_ACCESS;
`ifdef DM_SUBWORD_EN
            ST_ACCESS: state_nx = (we_q && !is_word(size_q)) ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_nx = ST_RESP;
`else
            ST_ACCESS: state_nx = ST_RESP;
`endif
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = state == ST_IDLE && RST_N;
        RSP_VALID = state == ST_RESP;
    end

    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;

    // Word stores write during ACCESS; sub-word stores merge in ACCESS and write during WRITE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DMWE    <= WE_IDLE;
            DMA     <= '0;
            DMWD    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
        end else if (accept) begin
            DMA     <= REQ_ADDR[DM_AW+1:2];
            DMWD    <= REQ_WDATA;
            DMWE    <= (REQ_WE && is_word(size_in) && !mis) ? WE_WRITE : WE_IDLE;
            rdata_q <= '0;
            err_q   <= mis;
            we_q    <= REQ_WE;
            size_q  <= size_in;
            off_q   <= off_in;
            uns_q   <= uns_in;
        end else if (state == ST_ACCESS) begin
            rdata_q <= we_q ? '0 : ld;
            DMWD    <= we_q ? merged : DMWD;
            DMWE    <= (we_q && !is_word(size_q)) ? WE_WRITE : WE_IDLE;
        end else begin
            DMWE <= WE_IDLE;
        end
    end

    dm_lane_align u_align (
        .rd     (DMRD),
        .wd     (DMWD),
        .size   (size_q),
        .off    (off_q),
        .uns    (uns_q),
        .ld     (ld),
        .merged (merged)
    );

endmodule
